dmem_lsu: RTL
=============

Name: dmem_lsu

Overview:
- Load/store initiator that drives the 16-bit core's data memory port (`mem_access_addr`, `mem_write_data`, `mem_write_en`, `mem_read`, `mem_read_data`).
- Accepts one load or store from the execute stage over a valid/ready request channel and computes the effective address as base plus sign-extended offset.
- Range-checks the address against memory depth, sequences the memory access, and returns a response over a valid/ready channel.
- Sits between the pipeline's execute/memory stage and the data memory.

Parameters:
- DATA_W, 16, data width.
- ADDR_W, 16, address width.
- OFF_W, 6, signed offset width.
- ROW_D, 8, number of data memory words; valid effective addresses are 0..ROW_D-1.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_base  in  ADDR_W  base register value.
- req_offset  in  OFF_W  signed two's-complement offset.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  load data; 0 for stores and for errors.
- rsp_err  out  1  effective address out of range; no memory access was made.
- mem_access_addr  out  ADDR_W  address to data memory.
- mem_write_data  out  DATA_W  write data to data memory.
- mem_write_en  out  1  write strobe; memory writes on the posedge where this is 1.
- mem_read  out  1  read enable; memory returns data combinationally.
- mem_read_data  in  DATA_W  read data from memory.

Behaviour:
- Reset (async, rst_n=0):
  - State to IDLE.
  - Address, wdata, rdata and err registers cleared to 0.
  - rsp_valid=0, mem_write_en=0, mem_read=0, mem_access_addr=0, mem_write_data=0, rsp_rdata=0, rsp_err=0.
  - req_ready=1 (decoded from IDLE).
- Reset mid-operation aborts immediately. A pending write strobe drops asynchronously, so no memory write occurs on any later edge.
- States: IDLE, WRITE, READ, RESP. All outputs are decoded from state flops or driven directly from registers; no input-to-output combinational path except the memory read capture.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch the request.
  - eff = req_base + sign_extend(req_offset), truncated to ADDR_W bits. Wrap-around is modular: 0x0000 + (-1) = 0xFFFF.
  - If eff >= ROW_D: err=1, rdata=0, go to RESP.
  - Else if req_we=1: go to WRITE.
  - Else: go to READ.
- WRITE: mem_write_en=1 for exactly one cycle, with mem_access_addr=eff and mem_write_data=latched wdata. rdata=0, err=0. Go to RESP.
- READ: mem_read=1 for exactly one cycle with mem_access_addr=eff. On the closing edge, capture mem_read_data into rdata; err=0. Go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_rdata and rsp_err held stable until rsp_ready=1 at a posedge, then go to IDLE.
  - rsp_ready asserted in the same cycle rsp_valid rises completes the handshake on that edge.
- req_ready=0 in WRITE, READ and RESP; requests presented then are not accepted and must be held by the source.
- mem_access_addr and mem_write_data hold their last latched values outside accesses. mem_write_en and mem_read are 0 outside WRITE and READ, and are never both 1.
- Timing, with request accepted at edge N:
  - Valid access: rsp_valid high after edge N+1.
  - Error: rsp_valid high after edge N.
  - Minimum spacing: 3 cycles per valid access, 2 cycles per error.

Decomposition:
- Shared Parameter.v header:
  - DATA_W/ADDR_W/OFF_W/ROW_D defaults, reusing the existing `col and `row_d defines for consistency.
  - State encodings: IDLE=2'd0, WRITE=2'd1, READ=2'd2, RESP=2'd3.
- One natural sub-module, dmem_agu: combinational sign-extend, add, and range compare producing eff[ADDR_W-1:0] and oob.

Test Plan:
- Store then load: store base=0x0002 off=+3 wdata=0xBEEF, then load base=0x0004 off=+1.
  - Store: mem_write_en high one cycle with addr=5, data=0xBEEF; rsp_rdata=0, rsp_err=0.
  - Load: rsp_valid at N+2 with rsp_rdata=0xBEEF.
- Negative offset: load base=0x0007 off=-7 (6'b111001) -> mem_access_addr=0x0000, mem_read one cycle, rsp_err=0.
- Out of range and wrap:
  - Store base=0x0000 off=-1 -> eff=0xFFFF: rsp_err=1 at N+1, mem_write_en never asserted, memory unchanged.
  - Load base=0x0008 off=0 -> rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after a load returning 0x1234.
  - rsp_valid and rsp_rdata=0x1234 stable throughout; req_ready=0.
  - Second req_valid not accepted until the cycle after the rsp handshake.
- Reset mid-operation: assert rst_n=0 during WRITE (mem_write_en=1) before the posedge.
  - mem_write_en falls immediately; target word unchanged; all outputs at reset values; req_ready=1.
- Back-to-back: 4 stores to addr 0..3 with req_valid held high and rsp_ready tied 1.
  - Accepts spaced exactly 3 cycles apart; readback of addr 0..3 returns the stored values.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared widths, memory depth and FSM encodings for the data-memory load/store unit.
package dmem_lsu_pkg;

   localparam int unsigned LSU_DATA_W = 16;
   localparam int unsigned LSU_ADDR_W = 16;
   localparam int unsigned LSU_OFF_W  = 6;
   localparam int unsigned LSU_ROW_D  = 8;

   typedef logic [1:0] lsu_state_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_READ  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/dmem_agu.sv
// Address generation: base plus sign-extended offset (modular), with range check against memory depth.
module dmem_agu
   import dmem_lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = LSU_ADDR_W,
   parameter int unsigned OFF_W  = LSU_OFF_W,
   parameter int unsigned ROW_D  = LSU_ROW_D
) (
   input  logic [ADDR_W-1:0] i_base,
   input  logic [OFF_W-1:0]  i_offset,
   output logic [ADDR_W-1:0] o_eff_c,
   output logic              o_oob_c
);

   logic [ADDR_W-1:0] w_off_sext;

   assign w_off_sext = {{(ADDR_W-OFF_W){i_offset[OFF_W-1]}}, i_offset};
   assign o_eff_c    = i_base + w_off_sext;
   assign o_oob_c    = (o_eff_c >= ADDR_W'(ROW_D));

endmodule

// File: rtl/dmem_lsu.sv
// Single-outstanding load/store initiator for the core's data memory port.
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int unsigned DATA_W = LSU_DATA_W,
   parameter int unsigned ADDR_W = LSU_ADDR_W,
   parameter int unsigned OFF_W  = LSU_OFF_W,
   parameter int unsigned ROW_D  = LSU_ROW_D
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_base,
   input  logic [OFF_W-1:0]  req_offset,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_access_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write_en,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_read_data
);

   lsu_state_t        r_state,     w_state_nxt;
   logic [ADDR_W-1:0] r_addr,      w_addr_nxt;
   logic [DATA_W-1:0] r_wdata,     w_wdata_nxt;
   logic [DATA_W-1:0] r_rdata,     w_rdata_nxt;
   logic              r_err,       w_err_nxt;
   logic              r_req_ready, w_req_ready_nxt;
   logic              r_mem_we,    w_mem_we_nxt;
   logic              r_mem_rd,    w_mem_rd_nxt;
   logic              r_rsp_valid, w_rsp_valid_nxt;
   logic [ADDR_W-1:0] w_eff_c;
   logic              w_oob_c;

   dmem_agu #(
      .ADDR_W (ADDR_W),
      .OFF_W  (OFF_W),
      .ROW_D  (ROW_D)
   ) u_agu (
      .i_base   (req_base),
      .i_offset (req_offset),
      .o_eff_c  (w_eff_c),
      .o_oob_c  (w_oob_c)
   );

   // Next state and next register values; control outputs are pre-decoded from the next state.
   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      w_rdata_nxt = r_rdata;
      w_err_nxt   = r_err;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_addr_nxt  = w_eff_c;
               w_wdata_nxt = req_wdata;
               w_rdata_nxt = '0;
               w_err_nxt   = w_oob_c;
               if (w_oob_c) begin
                  w_state_nxt = ST_RESP;
               end else if (req_we) begin
                  w_state_nxt = ST_WRITE;
               end else begin
                  w_state_nxt = ST_READ;
               end
            end
         end
         ST_WRITE: begin
            w_rdata_nxt = '0;
            w_err_nxt   = 1'b0;
            w_state_nxt = ST_RESP;
         end
         ST_READ: begin
            w_rdata_nxt = mem_read_data;
            w_err_nxt   = 1'b0;
            w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      w_req_ready_nxt = (w_state_nxt == ST_IDLE);
      w_mem_we_nxt    = (w_state_nxt == ST_WRITE);
      w_mem_rd_nxt    = (w_state_nxt == ST_READ);
      w_rsp_valid_nxt = (w_state_nxt == ST_RESP);
   end

   // Async reset drops any pending write strobe before the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
         r_req_ready <= 1'b1;
         r_mem_we    <= 1'b0;
         r_mem_rd    <= 1'b0;
         r_rsp_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_addr      <= w_addr_nxt;
         r_wdata     <= w_wdata_nxt;
         r_rdata     <= w_rdata_nxt;
         r_err       <= w_err_nxt;
         r_req_ready <= w_req_ready_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_rd    <= w_mem_rd_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
      end
   end

   assign req_ready       = r_req_ready;
   assign rsp_valid       = r_rsp_valid;
   assign rsp_rdata       = r_rdata;
   assign rsp_err         = r_err;
   assign mem_access_addr = r_addr;
   assign mem_write_data  = r_wdata;
   assign mem_write_en    = r_mem_we;
   assign mem_read        = r_mem_rd;

endmodule
